// File: rtl/pipe_adder.sv
// Chunk-serial adder: WIDTH/CHUNK cycles per op; holds result until out_ready, no overlap.
// Optional subtract port (a + ~b + 1) is compiled in with `define PIPE_ADDER_SUB_EN.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || WIDTH < 4) begin : g_bad_params
            $error("pipe_adder: WIDTH must be a multiple of CHUNK and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic [CHUNK:0]    chunk_add;
    logic              msb_carry_in;
    logic              op_sub;

`ifdef PIPE_ADDER_SUB_EN
    assign op_sub = sub;
`else
    assign op_sub = 1'b0;
`endif

    assign chunk_a   = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_b   = b_q[idx_q*CHUNK +: CHUNK];
    assign chunk_add = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit of this chunk, recovered from its sum bit.
    assign msb_carry_in = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_add[CHUNK-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction stores the inverted addend and forces carry-in to 1.
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d[idx_q*CHUNK +: CHUNK] = chunk_add[CHUNK-1:0];
                carry_d = chunk_add[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_add[CHUNK];
                    ovf_d   = msb_carry_in ^ chunk_add[CHUNK];
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised and directed bench for pipe_adder (WIDTH=16, CHUNK=4) against a queue-based arithmetic model.
`timescale 1ns/1ps
module tb_pipe_adder;
    localparam int W   = 16;
    localparam int NCH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub_v;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub       (sub_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    logic prev_ov = 1'b0;
    logic hs_seen = 1'b0;
    logic [17:0] exp_q[$];

    // {ovf, cout, sum} from plain integer arithmetic on the accepted operands.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic sb);
        logic [15:0] yy;
        logic [16:0] full;
        logic        ov;
        yy   = sb ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {16'd0, (sb ? 1'b1 : ci)};
        ov   = (x[15] == yy[15]) && (full[15] != x[15]);
        return {ov, full[16], full[15:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance / handshake observer.
    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub_v));
                acc_cyc = cyc + 1;
            end
            hs_seen = out_valid && out_ready;
            if (hs_seen && exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            hs_seen = 1'b0;
        end
    end

    // Compare process: every cycle the result is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hs_seen) begin
                check("idle_after_handshake", {30'd0, in_ready, out_valid}, 32'd2);
                hs_seen = 1'b0;
            end
            if (out_valid) begin
                if (!prev_ov) check("latency", cyc - acc_cyc, NCH);
                check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                if (exp_q.size() == 0) fail_now("unexpected_out_valid");
                else begin
                    check("sum",  {16'd0, sum},  {16'd0, exp_q[0][15:0]});
                    check("cout", {31'd0, cout}, {31'd0, exp_q[0][16]});
                    check("ovf",  {31'd0, ovf},  {31'd0, exp_q[0][17]});
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic sb, input int hold,
                         output logic [15:0] s, output logic co, output logic ov);
        int t;
        s = '0; co = 1'b0; ov = 1'b0;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (!in_ready) begin fail_now("timeout_in_ready"); return; end
        a = x; b = y; cin = ci; sub_v = sb; in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        if (!out_valid) begin fail_now("timeout_out_valid"); return; end
        s = sum; co = cout; ov = ovf;
        for (int i = 0; i < hold; i++) begin
            check("hold_stable", {14'd0, sum, cout, ovf}, {14'd0, s, co, ov});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
        end
        check("release_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [15:0] s, input logic co, input logic ov,
                       input logic [15:0] es, input logic eco, input logic eov);
        check({nm, "_sum"},  {16'd0, s},  {16'd0, es});
        check({nm, "_cout"}, {31'd0, co}, {31'd0, eco});
        check({nm, "_ovf"},  {31'd0, ov}, {31'd0, eov});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic co, ov, sb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub_v = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        rst_n = 1'b1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, s, co, ov);
        lit("v_ffff_1", s, co, ov, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, s, co, ov);
        lit("v_7fff_1", s, co, ov, 16'h8000, 1'b0, 1'b1);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0, s, co, ov);
        lit("v_1234", s, co, ov, 16'h5556, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, s, co, ov);
        lit("v_wrap_cin", s, co, ov, 16'h0000, 1'b1, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1, s, co, ov);
        lit("v_neg_ovf", s, co, ov, 16'h0000, 1'b1, 1'b1);
        do_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, 3, s, co, ov);
        lit("v_hold3", s, co, ov, 16'h1000, 1'b0, 1'b0);

        // Reset two cycles into BUSY abandons the operation.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 exp_q.delete();
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0, s, co, ov);
        lit("v_after_rst", s, co, ov, 16'h0007, 1'b0, 1'b0);

`ifdef PIPE_ADDER_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, s, co, ov);
        lit("v_sub_5_7", s, co, ov, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, s, co, ov);
        lit("v_sub_8000_1", s, co, ov, 16'h7FFF, 1'b1, 1'b1);
`endif

        for (int k = 0; k < 40; k++) begin
            sb = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
            sb = 1'($urandom);
`endif
            do_op(16'($urandom), 16'($urandom), 1'($urandom), sb, int'($urandom_range(0, 3)), s, co, ov);
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
